// File: rtl/sci_rom_streamer_pkg.sv
// rtl/sci_rom_streamer_pkg.sv - shared state encoding, terminator default and byte-select helper
package sci_rom_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h00;

    // Byte 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sci_rom_streamer.sv
// rtl/sci_rom_streamer.sv - walks the message ROM and unpacks words into a valid/ready byte stream
module sci_rom_streamer
    import sci_rom_streamer_pkg::*;
#(
    parameter int               ADDR_W    = 12,
    parameter logic [7:0]        TERM_BYTE = TERM_BYTE_DEFAULT,
    parameter logic [ADDR_W-1:0] END_ADDR  = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [31:0]       word_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0]        cur_byte;
    logic [7:0]        next_byte;
    logic              accept;

    assign cur_byte  = word_byte(word_q, byte_idx_q);
    assign next_byte = word_byte(word_q, byte_idx_q + 2'd1);
    assign accept    = tx_valid_q & tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort) begin
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rom_addr_q <= start_addr;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Present byte 0 straight from the ROM so it is valid on the first SEND cycle.
                    word_q     <= rom_data;
                    byte_idx_q <= 2'd0;
                    tx_data_q  <= rom_data[31:24];
                    tx_valid_q <= (rom_data[31:24] != TERM_BYTE);
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (cur_byte == TERM_BYTE) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (accept) begin
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            tx_data_q  <= next_byte;
                            tx_valid_q <= (next_byte != TERM_BYTE);
                        end else begin
                            tx_valid_q <= 1'b0;
                            if (rom_addr_q == END_ADDR) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                rom_addr_q <= rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                                state_q    <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sci_rom_streamer.sv
// tb/tb_sci_rom_streamer.sv - scoreboard bench with a word-walking reference model of the byte stream
module tb_sci_rom_streamer;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, tx_ready;
    logic [11:0] start_addr, rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;

    logic [31:0] rom [0:4095];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    sci_rom_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    int exp_done = 0, done_cnt = 0, hs_cnt = 0;
    int cycle = 0, start_cycle = 0, done_cycle = 0, first_valid_cycle = -1;
    int ready_mode = 0, ready_phase = 0;
    logic manual_ready = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // tx_ready driver: 0 always ready, 1 ready one cycle in three, 2 random, 3 manual
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: begin
                    tx_ready = (ready_phase == 0);
                    ready_phase = (ready_phase + 1) % 3;
                end
                2: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = manual_ready;
            endcase
        end
    end

    // Monitor: scoreboard pops on handshakes, checks hold while stalled, counts done pulses
    logic       pv = 1'b0, pr = 1'b0, pen = 1'b0;
    logic [7:0] pd = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            if (pv && !pr && pen) begin
                check("hold_valid", int'(tx_valid), 1);
                check("hold_data", int'(tx_data), int'(pd));
            end
            if (tx_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
            if (tx_valid && tx_ready && rst_n && !abort) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
                end else begin
                    check("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
            end
            pv  = tx_valid;
            pr  = tx_ready;
            pd  = tx_data;
            pen = rst_n && !abort;
        end
    end

    // Reference: walk words from addr, MSB byte first, stop at 0x00 or after the last word 0xFFF
    task automatic model(input logic [11:0] a);
        logic [11:0] ad;
        logic [7:0]  b;
        bit          stop;
        ad = a;
        stop = 0;
        while (!stop) begin
            for (int i = 0; i < 4 && !stop; i++) begin
                b = 8'(rom[ad] >> (24 - 8 * i));
                if (b == 8'h00) stop = 1;
                else exp_q.push_back(b);
            end
            if (!stop) begin
                if (ad == 12'hFFF) stop = 1;
                else ad = ad + 12'd1;
            end
        end
    endtask

    task automatic launch(input logic [11:0] a, input bit expect_done);
        model(a);
        if (expect_done) exp_done++;
        first_valid_cycle = -1;
        hs_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = a;
        start_cycle = cycle;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt < exp_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_count"}, done_cnt, exp_done);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_valid_seen"}, int'(tx_valid), 1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
        rom[0]     = 32'h48656C6C;
        rom[1]     = 32'h6F000000;
        rom[5]     = 32'h00112233;
        rom[12'hFFF] = 32'h41424344;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_addr = 12'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_valid", int'(tx_valid), 0);
        check("reset_tx_data", int'(tx_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        rst_n = 1'b1;

        // "Hello", always ready
        ready_mode = 0;
        launch(12'h0, 1);
        wait_done("hello");
        check("hello_handshakes", hs_cnt, 5);
        check("hello_first_valid_latency", first_valid_cycle - start_cycle, 2);

        // Same stream with a throttled receiver
        ready_mode = 1;
        launch(12'h0, 1);
        wait_done("hello_slow");
        check("hello_slow_handshakes", hs_cnt, 5);

        // Last legal word, no wrap
        ready_mode = 0;
        launch(12'hFFF, 1);
        wait_done("end_addr");
        check("end_addr_handshakes", hs_cnt, 4);
        check("end_addr_rom_addr", int'(rom_addr), 12'hFFF);

        // Terminator in byte 0
        launch(12'h5, 1);
        wait_done("term0");
        check("term0_handshakes", hs_cnt, 0);
        check("term0_done_latency", done_cycle - start_cycle, 3);

        // Abort while the 2nd byte is presented
        ready_mode = 3;
        manual_ready = 1'b0;
        launch(12'h0, 0);
        wait_valid("abort");
        manual_ready = 1'b1;
        @(posedge clk); #1;
        manual_ready = 1'b0;
        @(posedge clk); #1;
        check("abort_second_byte", int'(tx_data), 8'h65);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_tx_valid", int'(tx_valid), 0);
        check("abort_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, exp_done);
        ready_mode = 0;
        launch(12'h0, 1);
        wait_done("replay");
        check("replay_handshakes", hs_cnt, 5);

        // start while busy is ignored
        ready_mode = 3;
        launch(12'h0, 1);
        wait_valid("busy_start");
        start = 1'b1;
        start_addr = 12'h5;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_rom_addr", int'(rom_addr), 0);
        check("busy_start_data", int'(tx_data), 8'h48);
        ready_mode = 0;
        wait_done("busy_start");

        // Reset mid-SEND
        ready_mode = 3;
        launch(12'h0, 0);
        wait_valid("midreset");
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        check("midreset_tx_valid", int'(tx_valid), 0);
        check("midreset_tx_data", int'(tx_data), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_rom_addr", int'(rom_addr), 0);
        repeat (4) @(posedge clk);
        #1;
        check("midreset_no_done", done_cnt, exp_done);

        // Random ROM contents, random starts, random receiver
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] w;
            for (int k = 0; k < 4; k++) begin
                w = w << 8;
                w[7:0] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            rom[i] = w;
        end
        ready_mode = 2;
        for (int t = 0; t < 12; t++) begin
            logic [11:0] a;
            a = (t % 3 == 0) ? 12'($urandom_range(4090, 4095)) : 12'($urandom_range(0, 4095));
            launch(a, 1);
            wait_done("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
